pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Every cycle it decides whether each of the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC load or hold, and whether each one is cleared to a bubble. It handles three conditions:
- load-use hazards detected in ID;
- control redirects resolved in EX;
- multi-cycle data-memory accesses in MEM, with a bounded wait.

It sits beside the datapath and drives only enable/flush strobes; it never touches payload fields.

---
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Produces PC and pipeline-register enable/flush strobes for three cases:
// load-use hazards in ID, control redirects from EX and multi-cycle data-memory
// accesses in MEM (bounded by MEM_TIMEOUT).
// Optional feature macro: PIPE_PERF_CNT_EN adds the stall_cnt/flush_cnt
// performance counters and their ports.
// Handshake: dmem_req/dmem_ready act as valid/ready for one data-memory access;
// the access completes on a cycle where both are high, and the pipeline holds
// while dmem_req is high and dmem_ready is low, unless the wait has timed out.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             wait_state,
  output logic             mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_mem_err;
  logic              w_force_rel;
  logic              w_hold;
  logic              w_load_use;

  // The wait has reached its bound: this cycle releases regardless of ready.
  assign w_force_rel = (r_wcnt == WCNT_W'(MEM_TIMEOUT));
  assign w_hold      = dmem_req & ~dmem_ready & ~w_force_rel;
  // A load whose destination (other than x0) feeds the instruction in ID.
  assign w_load_use  = idex_memread & (idex_rd != 5'd0) &
                       ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  // State register; the state is also exported through wait_state.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state and strobes: memory hold beats redirect, redirect beats load-use.
  always_comb begin
    w_state_nxt = ST_RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (w_hold) begin
      // Freeze everything up to MEM; WB receives a bubble so no write repeats.
      w_state_nxt = ST_MEM_WAIT;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and IF/ID one cycle, insert a bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Wait counter: counts hold cycles of the current access, cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset)       r_wcnt <= '0;
    else if (w_hold) r_wcnt <= r_wcnt + WCNT_W'(1);
    else             r_wcnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                        r_mem_err <= 1'b0;
    else if (dmem_req & w_force_rel)  r_mem_err <= 1'b1;
  end

  assign wait_state = (r_state == ST_MEM_WAIT);
  assign mem_err    = r_mem_err;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Performance counters: stalled-PC cycles and redirect flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((ifid_flush | idex_flush) & ex_redirect)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized bench for pipe_hazard_ctrl.
// A behavioural model tracks the outstanding memory wait as a plain integer
// count and derives the required strobes from the hazard priority rules.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic       idex_memread = 1'b0, ex_redirect = 1'b0;
  logic       dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, memwb_flush, wait_state, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .wait_state(wait_state), .mem_err(mem_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Strobe vector order: pc ifid idex exmem memwb | ifid_f idex_f memwb_f
  bit          m_known = 1'b0;
  int          m_waited = 0;      // hold cycles spent on the current access
  bit          m_in_wait = 1'b0;
  bit          m_err = 1'b0;
  int unsigned m_stalls = 0;
  int unsigned m_flushes = 0;
  logic [7:0]  exp_q[$];

  function automatic bit model_hold();
    return dmem_req && !dmem_ready && (m_waited < TMO);
  endfunction

  function automatic bit model_load_use();
    return idex_memread && idex_rd != 0 &&
           (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  endfunction

  function automatic logic [7:0] model_strobes();
    if (model_hold())     return 8'b00001_001;
    if (ex_redirect)      return 8'b11111_110;
    if (model_load_use()) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always begin
    logic [7:0] exp_s;
    logic [7:0] act_s;
    bit         hold_now;
    @(negedge clk);
    if (m_known) begin
      exp_q.push_back(model_strobes());
      exp_s = exp_q.pop_front();
      act_s = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush};
      chk("strobes", 64'(act_s), 64'(exp_s));
      chk("wait_state", 64'(wait_state), 64'(m_in_wait));
      chk("mem_err", 64'(mem_err), 64'(m_err));
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
`endif
    end
    @(posedge clk);
    // Inputs are still those of the cycle just checked.
    hold_now = model_hold();
    if (reset) begin
      m_known = 1'b1; m_waited = 0; m_in_wait = 1'b0; m_err = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else if (m_known) begin
      if (dmem_req && m_waited == TMO) m_err = 1'b1;
      if (!hold_now && (ex_redirect || model_load_use()) && !ex_redirect)
        m_stalls++;
      else if (hold_now)
        m_stalls++;
      if (!hold_now && ex_redirect) m_flushes++;
      m_in_wait = hold_now;
      m_waited  = hold_now ? m_waited + 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input bit rst, input bit mr, input int rd, input int rs1,
                       input int rs2, input bit redir, input bit req, input bit rdy);
    @(posedge clk);
    #2;
    reset = rst; idex_memread = mr; idex_rd = 5'(rd);
    ifid_rs1 = 5'(rs1); ifid_rs2 = 5'(rs2);
    ex_redirect = redir; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_wait_state", 64'(wait_state), 64'd0);
    chk("rst_mem_err", 64'(mem_err), 64'd0);
    chk("rst_pc_en", 64'(pc_en), 64'd1);

    // load-use: one bubble, then the bubble in ID/EX clears the stall
    apply(0, 1, 5, 1, 5, 0, 0, 0);
    settle();
    chk("lu_pc_en", 64'(pc_en), 64'd0);
    chk("lu_ifid_en", 64'(ifid_en), 64'd0);
    chk("lu_idex_flush", 64'(idex_flush), 64'd1);
    apply(0, 0, 0, 1, 5, 0, 0, 0);
    settle();
    chk("lu_after_pc_en", 64'(pc_en), 64'd1);
    chk("lu_after_idex_flush", 64'(idex_flush), 64'd0);

    // rd = x0 never stalls
    apply(0, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("x0_pc_en", 64'(pc_en), 64'd1);
    chk("x0_idex_flush", 64'(idex_flush), 64'd0);

    // redirect with a load-use hazard: redirect wins
    idle_reset();
    apply(0, 1, 5, 5, 0, 1, 0, 0);
    settle();
    chk("rd_ifid_flush", 64'(ifid_flush), 64'd1);
    chk("rd_idex_flush", 64'(idex_flush), 64'd1);
    chk("rd_pc_en", 64'(pc_en), 64'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
`ifdef PIPE_PERF_CNT_EN
    chk("rd_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("rd_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // memory access with 3 wait cycles
    idle_reset();
    for (int c = 1; c <= 3; c++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      chk("mem_hold_strobes",
          64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_flush}), 64'b000011);
      chk("mem_hold_wait", 64'(wait_state), (c == 1) ? 64'd0 : 64'd1);
    end
    apply(0, 0, 0, 0, 0, 0, 1, 1);
    settle();
    chk("mem_rel_wait", 64'(wait_state), 64'd1);
    chk("mem_rel_pc_en", 64'(pc_en), 64'd1);
`ifdef PIPE_PERF_CNT_EN
    chk("mem_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mem_after_wait", 64'(wait_state), 64'd0);

    // timeout: TMO holds, release on the next cycle, sticky error afterwards
    for (int c = 1; c <= TMO + 1; c++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      chk("tmo_pc_en", 64'(pc_en), (c <= TMO) ? 64'd0 : 64'd1);
    end
    chk("tmo_err_before", 64'(mem_err), 64'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("tmo_err_after", 64'(mem_err), 64'd1);
    chk("tmo_wait_after", 64'(wait_state), 64'd0);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("tmo_wcnt_cleared", 64'(pc_en), 64'd0);

    // reset on the 2nd hold cycle
    apply(1, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("rstw_pc_en", 64'(pc_en), 64'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rstw_wait", 64'(wait_state), 64'd0);
    chk("rstw_err", 64'(mem_err), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("rstw_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    fork
      wait (done);
      begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL timeout got running expected done");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
